// File: rtl/fifo8_if.sv
// Handshake and RAM8 bus bundle for fifo8_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface fifo8_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  count;
    logic [2:0]  ram_addr;
    logic [15:0] ram_in;
    logic        ram_write;
    logic [15:0] ram_out;

    modport slave (
        input  in_valid, in_data, out_ready, ram_out,
        output in_ready, out_valid, out_data, count, ram_addr, ram_in, ram_write
    );

    modport master (
        output in_valid, in_data, out_ready, ram_out,
        input  in_ready, out_valid, out_data, count, ram_addr, ram_in, ram_write
    );
endinterface

// File: rtl/fifo8_ctrl.sv
// 9-word FIFO controller over an external RAM8 with a prefetched head register.
// Optional macro FIFO8_BYPASS_EN lets a push into an empty RAM go straight to the head register.
module fifo8_ctrl (
    input  logic    clk,
    input  logic    rst_n,
    fifo8_if.slave  bus
);

    logic [2:0]  wr_ptr_q,    wr_ptr_d;
    logic [2:0]  rd_ptr_q,    rd_ptr_d;
    logic [3:0]  ram_cnt_q,   ram_cnt_d;
    logic [3:0]  count_q,     count_d;
    logic [15:0] out_data_q,  out_data_d;
    logic        out_valid_q, out_valid_d;

    logic pop;
    logic slot_free;
    logic prefetch;
    logic bypass_ok;
    logic ram_room;
    logic in_ready;
    logic bypass_push;
    logic ram_push;

    // RAM8 has a single address, so a prefetch read blocks any push that would need the RAM.
    always_comb begin
        pop       = out_valid_q & bus.out_ready;
        slot_free = !out_valid_q | pop;
        prefetch  = slot_free & (ram_cnt_q != 4'd0);
`ifdef FIFO8_BYPASS_EN
        bypass_ok = slot_free & (ram_cnt_q == 4'd0);
`else
        bypass_ok = 1'b0;
`endif
        ram_room    = ram_cnt_q < 4'd8;
        in_ready    = rst_n & !prefetch & (bypass_ok | ram_room);
        bypass_push = bus.in_valid & in_ready & bypass_ok;
        ram_push    = bus.in_valid & in_ready & !bypass_ok;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (prefetch) begin
            out_data_d  = bus.ram_out;
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + 3'd1;
            ram_cnt_d   = ram_cnt_q - 4'd1;
        end else if (bypass_push) begin
            out_data_d  = bus.in_data;
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        if (ram_push) begin
            wr_ptr_d  = wr_ptr_q + 3'd1;
            ram_cnt_d = ram_cnt_q + 4'd1;
        end

        count_d = ram_cnt_d + {3'b000, out_valid_d};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= 3'd0;
            rd_ptr_q    <= 3'd0;
            ram_cnt_q   <= 4'd0;
            count_q     <= 4'd0;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.count     = count_q;
    assign bus.ram_write = ram_push;
    assign bus.ram_addr  = ram_push ? wr_ptr_q : rd_ptr_q;
    assign bus.ram_in    = bus.in_data;

endmodule
